fir_ctrl: RTL
=============

FIR_CTRL -- requirements
Module: fir_ctrl

Interface
REQ-001 Parameter NCOEF, default 19: coefficient words per load, matching the filter tap-register count.
REQ-002 Parameter FLUSH_LEN, default 37: zero samples driven after a load, matching the filter delay-line depth.
REQ-003 Parameter PIPE_LAT, default 8: cycles from sample accept to valid filter output.
REQ-004 CLK  in  1  single clock; all state on rising edge.
REQ-005 RESET  in  1  asynchronous, active-low reset.
REQ-006 cfg_start  in  1  single-cycle pulse requesting a coefficient (re)load.
REQ-007 coef_valid / coef_data / coef_ready  in / in / out  1 / 16 / 1  coefficient handshake.
REQ-008 s_valid / s_data / s_ready  in / in / out  1 / 16 / 1  input sample handshake.
REQ-009 fir_wr / fir_data  out / out  1 / 16  filter WR and iDATA drive, combinational from state and inputs.
REQ-010 fir_odata  in  39  filter oDATA.
REQ-011 m_valid / m_data  out / out  1 / 39  filtered output strobe and value.
REQ-012 busy  out  1  high in LOAD or FLUSH.
REQ-013 underrun_cnt  out  16  RUN cycles with s_valid low.

Function
REQ-014 The block SHALL implement states IDLE, LOAD, FLUSH and RUN.
REQ-015 IDLE: fir_wr=0, fir_data=0, coef_ready=0, s_ready=0; cfg_start moves the block to LOAD.
REQ-016 LOAD: coef_ready=1, fir_wr=coef_valid, fir_data=coef_data; each coef_valid cycle is one accept and increments coef_cnt (0..NCOEF-1).
REQ-017 LOAD SHALL move to FLUSH on the accept taken at coef_cnt=NCOEF-1, resetting coef_cnt to 0; exactly NCOEF fir_wr pulses per load keep the filter write index aligned.
REQ-018 FLUSH: fir_wr=0, fir_data=0, coef_ready=0, s_ready=0 for exactly FLUSH_LEN cycles (flush_cnt 0..FLUSH_LEN-1), then RUN.
REQ-019 RUN: s_ready=1, fir_wr=0, fir_data = s_valid ? s_data : 0; a bubble is a zero sample and the filter advances every cycle.
REQ-020 A tag shift register of PIPE_LAT bits SHALL shift every cycle while fir_wr=0; tag[0] <= (RUN and s_valid).
REQ-021 m_valid = tag[PIPE_LAT-1]; m_data = fir_odata when m_valid is high, else 0; latency is 8 cycles from the accept cycle.
REQ-022 Tags SHALL hold while fir_wr=1, and all tags SHALL clear when LOAD is entered.
REQ-023 cfg_start in RUN SHALL enter LOAD on the next edge, with no s_ready in that cycle after the pulse.
REQ-024 cfg_start in LOAD or FLUSH SHALL be ignored.
REQ-025 underrun_cnt SHALL increment on each RUN cycle with s_valid=0, saturate at 16'hFFFF, and clear when LOAD is entered.
REQ-026 Filter arithmetic is unsigned; m_data is passed through unmodified at 39 bits.

Reset
REQ-027 On RESET low, the state SHALL go to IDLE asynchronously.
REQ-028 On RESET low, coef_cnt, flush_cnt, tags and underrun_cnt SHALL go to 0.
REQ-029 On RESET low, all outputs SHALL be 0 (coef_ready, s_ready, fir_wr, fir_data, m_valid, m_data, busy, underrun_cnt).
REQ-030 Reset mid-LOAD is legal; the shared filter reset re-aligns its write index, and a full reload is required afterwards.

Verification
REQ-031 Reset, cfg_start, then 19 back-to-back coefs -> 19 fir_wr pulses with data equal to the inputs; busy high; FLUSH lasts 37 cycles with fir_data=0; RUN is entered on cycle 57 after cfg_start.
REQ-032 Coefs coef[18]=1 and all others 0; impulse 100 then zeros in RUN -> m_data=100 exactly 8+18 cycles after the impulse accept, and all other m_valid outputs are 0.
REQ-033 Coefs all 1; constant sample 1 for 40 cycles -> steady-state m_data=37.
REQ-034 Coef stream with coef_valid toggling every other cycle -> fir_wr only on valid cycles, and FLUSH is entered after the 19th accept.
REQ-035 In RUN, s_valid low for 5 cycles -> underrun_cnt=5, fir_data=0 in those cycles, and no m_valid 8 cycles later.
REQ-036 cfg_start mid-RUN with tags in flight -> tags cleared, no m_valid, and underrun_cnt=0; cfg_start pulses during LOAD are ignored.

Source files
------------

// File: rtl/fir_ctrl.sv
// fir_ctrl: sequencer sitting in front of a symmetric FIR filter core.
//
// It loads NCOEF coefficient words into the filter through its WR/iDATA
// port, drives FLUSH_LEN zero samples so that the delay line starts clean,
// and then streams input samples into the filter every cycle. Missing
// samples become zero bubbles. A PIPE_LAT-deep tag pipeline follows each
// accepted sample through the filter so that the filter output is qualified
// only for real samples.
//
// Ports
//   clk           clock, all state on the rising edge
//   rst_n         asynchronous active-low reset
//   cfg_start     single-cycle pulse requesting a coefficient (re)load
//   coef_valid    coefficient word present on coef_data
//   coef_data     coefficient word (16 bit)
//   coef_ready    high while coefficient words are being taken
//   s_valid       input sample present on s_data
//   s_data        input sample (16 bit)
//   s_ready       high while samples are being streamed into the filter
//   fir_wr        filter WR strobe (coefficient write)
//   fir_data      filter iDATA drive (coefficient or sample)
//   fir_odata     filter oDATA (39 bit, unsigned)
//   m_valid       filtered output strobe
//   m_data        filtered output value, zero when m_valid is low
//   busy          high while loading or flushing
//   underrun_cnt  streaming cycles without an input sample (saturating)

module fir_ctrl #(
    parameter int NCOEF     = 19,
    parameter int FLUSH_LEN = 37,
    parameter int PIPE_LAT  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_start,
    input  logic        coef_valid,
    input  logic [15:0] coef_data,
    output logic        coef_ready,
    input  logic        s_valid,
    input  logic [15:0] s_data,
    output logic        s_ready,
    output logic        fir_wr,
    output logic [15:0] fir_data,
    input  logic [38:0] fir_odata,
    output logic        m_valid,
    output logic [38:0] m_data,
    output logic        busy,
    output logic [15:0] underrun_cnt
);

    localparam int CW = (NCOEF > 1) ? $clog2(NCOEF) : 1;
    localparam int FW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FLUSH,
        RUN
    } state_t;

    state_t              state;
    logic [CW-1:0]       coef_cnt;
    logic [FW-1:0]       flush_cnt;
    logic [PIPE_LAT-1:0] tags;
    logic                load_req;
    logic                run_accept;

    // A reload is honoured only from IDLE or RUN; pulses while loading or
    // flushing are dropped so the filter write index never gets out of step.
    assign load_req   = cfg_start && ((state == IDLE) || (state == RUN));
    assign run_accept = (state == RUN) && s_valid;

    // Filter drive is combinational so the coefficient or sample reaches the
    // filter in the same cycle it is presented.
    always_comb begin
        fir_wr   = 1'b0;
        fir_data = '0;
        case (state)
            LOAD: begin
                fir_wr   = coef_valid;
                fir_data = coef_data;
            end
            RUN: begin
                fir_data = s_valid ? s_data : '0;
            end
            default: begin
                fir_wr   = 1'b0;
                fir_data = '0;
            end
        endcase
    end

    assign m_valid = tags[PIPE_LAT-1];
    assign m_data  = m_valid ? fir_odata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            coef_cnt     <= '0;
            flush_cnt    <= '0;
            tags         <= '0;
            underrun_cnt <= '0;
            coef_ready   <= 1'b0;
            s_ready      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            // The filter pipeline only advances on non-write cycles, so the
            // tags stall together with it.
            if (!fir_wr) begin
                tags <= {tags[PIPE_LAT-2:0], run_accept};
            end

            if ((state == RUN) && !s_valid && (underrun_cnt != '1)) begin
                underrun_cnt <= underrun_cnt + 16'd1;
            end

            case (state)
                LOAD: begin
                    if (coef_valid) begin
                        if (coef_cnt == CW'(NCOEF - 1)) begin
                            coef_cnt   <= '0;
                            state      <= FLUSH;
                            coef_ready <= 1'b0;
                        end else begin
                            coef_cnt <= coef_cnt + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_cnt == FW'(FLUSH_LEN - 1)) begin
                        flush_cnt <= '0;
                        state     <= RUN;
                        busy      <= 1'b0;
                        s_ready   <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase

            // Entering LOAD overrides the tag shift and the underrun update
            // above: nothing in flight survives a reload.
            if (load_req) begin
                state        <= LOAD;
                coef_cnt     <= '0;
                tags         <= '0;
                underrun_cnt <= '0;
                coef_ready   <= 1'b1;
                s_ready      <= 1'b0;
                busy         <= 1'b1;
            end
        end
    end

endmodule
